avalon_bus_arbiter: RTL and testbench
=====================================

# avalon_bus_arbiter

Two-master, one-slave Avalon memory-mapped arbiter sharing the single bus memory between `mips_cpu_bus` (master 0) and a second master such as a testbench loader or DMA engine (master 1). Grants are registered and held for exactly one transfer at a time, with round-robin fairness on contention. Requests pass to the slave with no added latency once granted, and back-to-back transfers cause no idle bubbles. The block sits between the CPU's Avalon port and the memory model.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `m0_address`  in  ADDR_W  master 0 (CPU) address
- `m0_read`, `m0_write`  in  1  master 0 request strobes
- `m0_writedata`  in  DATA_W  master 0 write data
- `m0_byteenable`  in  DATA_W/8  master 0 byte enables
- `m0_waitrequest`  out  1  stall to master 0
- `m0_readdata`  out  DATA_W  read data to master 0
- `m1_*`  (same set as `m0_*`)  master 1
- `s_address`, `s_read`, `s_write`, `s_writedata`, `s_byteenable`  out  —  to slave
- `s_waitrequest`  in  1  slave stall
- `s_readdata`  in  DATA_W  slave read data
- `grant`  out  2  one-hot current grant {m1,m0}; 2'b00 when idle
- `proto_err`  out  1  sticky: a granted master asserted read and write together

## Operation
- Request: `mN_req = mN_read | mN_write`. Masters obey Avalon: hold address/strobes/data stable while their waitrequest is high.
- States: IDLE, GNT0, GNT1. Register `last` records the master most recently served.
- IDLE: all `s_*` strobes 0, both `mN_waitrequest` = 1. One requester → grant it next cycle. Both request → grant the master that is not `last`. No requests → stay.
- GNTn: `s_address/s_read/s_write/s_writedata/s_byteenable` = master n inputs (combinational mux). `mN_waitrequest` = `s_waitrequest` for the granted master and 1 for the other master.
- Completion: in GNTn, a transfer completes when `mn_req & ~s_waitrequest`. On completion `last <= n`, and the next state is:
  - GNT(other) if the other master is requesting;
  - otherwise GNTn if master n is still requesting (a new transfer);
  - otherwise IDLE.
- Grant dropped: in GNTn with `mn_req` = 0 (protocol violation or abort), go to GNT(other) if the other master is requesting, else IDLE. `last` is unchanged.
- `s_readdata` is broadcast to both `mN_readdata`. It is meaningful only to the granted master in the cycle its waitrequest is low.
- `proto_err` is set when, in GNTn, `mn_read & mn_write`. Both strobes are still forwarded. The flag clears only on reset.
- `grant` decodes from state: IDLE = 00, GNT0 = 01, GNT1 = 10.

## Timing
- Reset (async, `reset`=0):
  - state IDLE, `last`=1 so master 0 wins the first contention, `proto_err`=0;
  - outputs immediately: `s_read`=`s_write`=0, both waitrequests = 1, `grant`=00.
- Reset asserted mid-transfer aborts it. `s_*` strobes drop within the same cycle, with no clock required.
- Arbitration latency: a request seen in IDLE at edge N is granted from cycle N+1. With `s_waitrequest`=0, it completes in cycle N+1 (one-cycle penalty from idle).
- Granted path: zero-cycle combinational pass-through both ways (master→slave and `s_waitrequest`→master).
- Contention with a zero-wait slave: grants alternate every cycle with no idle cycle between transfers.
- A single master issuing continuously stays granted with no bubbles.
- A master never waits more than one other transfer once it is requesting (starvation bound).
- Slave wait states extend GNTn indefinitely. There is no timeout and no preemption.
- Simultaneous completion of master n and a new request from master n, with the other master requesting → the other master is served next.

## Test plan
- Reset/idle: hold `reset`=0, then release with no requests → `grant`=00, `s_read`=`s_write`=0, both waitrequests = 1 for 10 cycles.
- Single CPU read: `m0_read`=1, `m0_address`=0xBFC00000, `s_waitrequest`=0, `s_readdata`=0x24020005 → `grant`=01 the cycle after the request, `s_address`=0xBFC00000, `m0_waitrequest`=0 that cycle, `m0_readdata`=0x24020005, and IDLE after `m0_read` drops.
- Contention from idle: m0 and m1 both request continuously with a zero-wait slave → grant sequence 01, 10, 01, 10 with no 00 between; `m1_waitrequest`=1 whenever `grant`=01.
- Wait states: m1 writes 0xDEADBEEF to 0x1000 with byteenable 4'b0011 while the slave holds `s_waitrequest`=1 for 3 cycles; m0 requests meanwhile → `grant` stays 10 for 3 cycles, then completes, then switches to 01. Memory at 0x1000 shows only the low halfword written.
- Async reset mid-transfer: assert `reset`=0 between clock edges during GNT0 with the slave stalled → `s_read` falls before the next edge; after release, the first contention is won by m0.
- Protocol error: `m0_read`=`m0_write`=1 while granted → `proto_err` rises and stays 1 after the strobes clear, until reset.

Source files
------------

// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter: two-master, one-slave Avalon-MM arbiter with a registered round-robin grant
// Ports: clk, reset (async active-low); m0_*/m1_* master ports (m0 = CPU);
//        s_* slave port; grant one-hot {m1,m0}, 00 when idle; proto_err sticky read+write flag.
module avalon_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    output logic [1:0]          grant,
    output logic                proto_err
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t state_q, state_d, own_st, oth_st;
    logic last_q, last_d, proto_err_q, proto_err_d;
    logic req0, req1, sel, cur_req, oth_req, done;
    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        sel = state_q == GNT1;
        cur_req = sel ? req1 : req0;
        oth_req = sel ? req0 : req1;
        own_st = sel ? GNT1 : GNT0;
        oth_st = sel ? GNT0 : GNT1;
        done = state_q != IDLE & cur_req & ~s_waitrequest;
        state_d = state_q;
        last_d = done ? sel : last_q;
        proto_err_d = proto_err_q | (state_q != IDLE & (sel ? m1_read & m1_write : m0_read & m0_write));
        // Completion and dropped grants share one hand-off rule: the other master first.
        if (state_q == IDLE)
            state_d = req0 & req1 ? (last_q ? GNT0 : GNT1) : req0 ? GNT0 : req1 ? GNT1 : IDLE;
        else if (done | ~cur_req)
            state_d = oth_req ? oth_st : cur_req ? own_st : IDLE;
    end
    always_comb begin
        s_address = sel ? m1_address : m0_address;
        s_writedata = sel ? m1_writedata : m0_writedata;
        s_byteenable = sel ? m1_byteenable : m0_byteenable;
        s_read = state_q == GNT0 ? m0_read : state_q == GNT1 ? m1_read : 1'b0;
        s_write = state_q == GNT0 ? m0_write : state_q == GNT1 ? m1_write : 1'b0;
        m0_waitrequest = state_q == GNT0 ? s_waitrequest : 1'b1;
        m1_waitrequest = state_q == GNT1 ? s_waitrequest : 1'b1;
        m0_readdata = s_readdata;
        m1_readdata = s_readdata;
        grant = {state_q == GNT1, state_q == GNT0};
        proto_err = proto_err_q;
    end
    // last resets to 1 so master 0 wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q <= 1'b1;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// tb_avalon_bus_arbiter: directed bench with a cycle model of the arbitration rules
module tb_avalon_bus_arbiter;
    logic        clk, reset;
    logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  s_byteenable;
    logic [1:0]  grant;
    logic        proto_err;
    logic [31:0] mem1000;
    int total = 0, bad = 0;
    int m_own = -1, m_last = 1, m_perr = 0;
    logic [1:0] seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory word at 0x1000, written byte-by-byte as the slave accepts writes.
    always @(posedge clk or negedge reset) begin
        if (!reset) mem1000 <= 32'h0;
        else if (s_write && !s_waitrequest && s_address == 32'h1000)
            for (int i = 0; i < 4; i++) if (s_byteenable[i]) mem1000[8*i +: 8] <= s_writedata[8*i +: 8];
    end

    // Model: which master owns the bus (-1 none), who was served last, sticky error.
    always @(posedge clk or negedge reset) begin : model
        int rq [2];
        int rw [2];
        int n;
        if (!reset) begin
            m_own <= -1;
            m_last <= 1;
            m_perr <= 0;
        end else begin
            rq[0] = int'(m0_read | m0_write);
            rq[1] = int'(m1_read | m1_write);
            rw[0] = int'(m0_read & m0_write);
            rw[1] = int'(m1_read & m1_write);
            if (m_own < 0) begin
                if (rq[0] + rq[1] == 2) m_own <= 1 - m_last;
                else if (rq[0] + rq[1] == 1) m_own <= rq[0] == 1 ? 0 : 1;
            end else begin
                n = m_own;
                if (rq[n] == 1 && !s_waitrequest) m_last <= n;
                if (rq[n] == 0 || !s_waitrequest) m_own <= rq[1-n] == 1 ? 1 - n : (rq[n] == 1 ? n : -1);
                if (rw[n] == 1) m_perr <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("m_grant", grant, m_own < 0 ? 2'b00 : (m_own == 0 ? 2'b01 : 2'b10));
            chk("m_s_read", s_read, m_own < 0 ? 1'b0 : (m_own == 0 ? m0_read : m1_read));
            chk("m_s_write", s_write, m_own < 0 ? 1'b0 : (m_own == 0 ? m0_write : m1_write));
            chk("m_m0_wait", m0_waitrequest, m_own == 0 ? s_waitrequest : 1'b1);
            chk("m_m1_wait", m1_waitrequest, m_own == 1 ? s_waitrequest : 1'b1);
            chk("m_rdata0", m0_readdata, s_readdata);
            chk("m_rdata1", m1_readdata, s_readdata);
            chk("m_perr", proto_err, m_perr[0]);
            if (m_own >= 0) begin
                chk("m_s_addr", s_address, m_own == 1 ? m1_address : m0_address);
                chk("m_s_wdata", s_writedata, m_own == 1 ? m1_writedata : m0_writedata);
                chk("m_s_be", s_byteenable, m_own == 1 ? m1_byteenable : m0_byteenable);
            end
        end
    end

    initial begin
        clk = 0; reset = 0;
        m0_address = 0; m0_read = 0; m0_write = 0; m0_writedata = 0; m0_byteenable = 4'hF;
        m1_address = 0; m1_read = 0; m1_write = 0; m1_writedata = 0; m1_byteenable = 4'hF;
        s_waitrequest = 0; s_readdata = 0;
        cyc(3);
        chk("rst_grant", grant, 2'b00);
        chk("rst_sread", s_read, 1'b0);
        chk("rst_m0wait", m0_waitrequest, 1'b1);
        reset = 1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("idle_grant", grant, 2'b00);
            chk("idle_strobes", {s_read, s_write}, 2'b00);
            chk("idle_waits", {m1_waitrequest, m0_waitrequest}, 2'b11);
        end
        // contention from idle, zero-wait slave
        m0_read = 1; m0_address = 32'h100; m1_read = 1; m1_address = 32'h200;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("cont_grant", grant, seq[i]);
            chk("cont_m1_wait", m1_waitrequest, seq[i] == 2'b01 ? 1'b1 : 1'b0);
        end
        m0_read = 0; m1_read = 0;
        cyc(1);
        chk("cont_idle", grant, 2'b00);
        // single CPU read
        m0_read = 1; m0_address = 32'hBFC00000; s_readdata = 32'h24020005;
        cyc(1);
        chk("rd_grant", grant, 2'b01);
        chk("rd_saddr", s_address, 32'hBFC00000);
        chk("rd_m0wait", m0_waitrequest, 1'b0);
        chk("rd_rdata", m0_readdata, 32'h24020005);
        cyc(1);
        m0_read = 0;
        cyc(1);
        chk("rd_idle", grant, 2'b00);
        // m1 halfword write under slave wait states, m0 contending
        m1_write = 1; m1_address = 32'h1000; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'b0011;
        m0_read = 1; m0_address = 32'h2000; s_waitrequest = 1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("ws_grant_m1", grant, 2'b10);
        end
        s_waitrequest = 0;
        cyc(1);
        chk("ws_grant_m0", grant, 2'b01);
        chk("ws_mem", mem1000, 32'h0000BEEF);
        m1_write = 0;
        cyc(1);
        m0_read = 0;
        cyc(1);
        chk("ws_idle", grant, 2'b00);
        // async reset during a stalled m0 transfer
        m0_read = 1; m0_address = 32'h3000; s_waitrequest = 1;
        cyc(1);
        chk("ar_grant", grant, 2'b01);
        chk("ar_sread_hi", s_read, 1'b1);
        #2 reset = 0;
        #1;
        chk("ar_sread_lo", s_read, 1'b0);
        chk("ar_grant_lo", grant, 2'b00);
        chk("ar_m0wait", m0_waitrequest, 1'b1);
        m0_read = 0; s_waitrequest = 0;
        cyc(1);
        reset = 1; m0_read = 1; m1_read = 1;
        cyc(1);
        chk("ar_first_win", grant, 2'b01);
        m0_read = 0; m1_read = 0;
        cyc(1);
        chk("ar_idle", grant, 2'b00);
        // protocol error: read and write together while granted
        m0_read = 1; m0_write = 1; m0_writedata = 32'h12345678; m0_address = 32'h40;
        cyc(1);
        chk("pe_grant", grant, 2'b01);
        chk("pe_pre", proto_err, 1'b0);
        chk("pe_both_fwd", {s_read, s_write}, 2'b11);
        cyc(1);
        chk("pe_set", proto_err, 1'b1);
        m0_read = 0; m0_write = 0;
        cyc(3);
        chk("pe_sticky", proto_err, 1'b1);
        reset = 0;
        #1;
        chk("pe_clear", proto_err, 1'b0);
        cyc(1);
        reset = 1;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
